mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/cpu_consts.sv | 62 ++++++
 rtl/mem_access_if.sv | 22 ++
 rtl/load_align.sv | 27 ++
 rtl/mem_access.sv | 152 +++++++++++++++
 tb/tb_mem_access.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_consts.sv
// Shared CPU constants: ALU op codes, memory op/size enums, byte-mask and alignment helpers.
`timescale 1ns/1ps
package cpu_consts;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2,
        MEM_RSVD  = 2'd3
    } mem_op_t;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } mem_size_t;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    function automatic logic [7:0] size_mask(input mem_size_t size);
        case (size)
            SIZE_B:  size_mask = MASK_B;
            SIZE_H:  size_mask = MASK_H;
            SIZE_W:  size_mask = MASK_W;
            SIZE_D:  size_mask = MASK_D;
            default: size_mask = MASK_B;
        endcase
    endfunction

    // Mask of address offset bits that survive alignment to the access size.
    function automatic logic [2:0] align_bits(input mem_size_t size);
        case (size)
            SIZE_B:  align_bits = 3'b111;
            SIZE_H:  align_bits = 3'b110;
            SIZE_W:  align_bits = 3'b100;
            SIZE_D:  align_bits = 3'b000;
            default: align_bits = 3'b111;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] offset, input mem_size_t size);
        is_misaligned = ((offset & ~align_bits(size)) != 3'b000);
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Memory request/response port between the memory-access stage and the data memory.
`timescale 1ns/1ps
interface mem_access_if;
    logic        req_valid_o;
    logic        req_ready_i;
    logic [63:0] req_addr_o;
    logic        req_we_o;
    logic [63:0] req_wdata_o;
    logic [7:0]  req_wstrb_o;
    logic        resp_valid_i;
    logic [63:0] resp_rdata_i;

    modport master (
        output req_valid_o, req_addr_o, req_we_o, req_wdata_o, req_wstrb_o,
        input  req_ready_i, resp_valid_i, resp_rdata_i
    );

    modport slave (
        input  req_valid_o, req_addr_o, req_we_o, req_wdata_o, req_wstrb_o,
        output req_ready_i, resp_valid_i, resp_rdata_i
    );
endinterface

// File: rtl/load_align.sv
// Load data lane extraction: picks the addressed bytes and sign/zero-extends them to 64 bits.
`timescale 1ns/1ps
module load_align
    import cpu_consts::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  offset,
    input  mem_size_t   size,
    input  logic        is_unsigned,
    output logic [63:0] data
);

    logic [63:0] lane_s;

    // Shift addressed lane to bit 0, then extend according to size and signedness.
    always_comb begin
        lane_s = rdata >> {offset, 3'b000};
        case (size)
            SIZE_B:  data = is_unsigned ? {56'd0, lane_s[7:0]}  : {{56{lane_s[7]}},  lane_s[7:0]};
            SIZE_H:  data = is_unsigned ? {48'd0, lane_s[15:0]} : {{48{lane_s[15]}}, lane_s[15:0]};
            SIZE_W:  data = is_unsigned ? {32'd0, lane_s[31:0]} : {{32{lane_s[31]}}, lane_s[31:0]};
            SIZE_D:  data = lane_s;
            default: data = lane_s;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: IDLE/REQ/WAIT/DONE FSM issuing loads/stores and presenting writeback.
// Build option MISALIGN_TRAP_EN: misaligned loads/stores trap (exc_o) instead of being force-aligned.
`timescale 1ns/1ps
module mem_access
    import cpu_consts::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [63:0]   alu_res_i,
    input  logic [63:0]   store_data_i,
    input  logic [1:0]    mem_op_i,
    input  logic [1:0]    mem_size_i,
    input  logic          mem_unsigned_i,
    input  logic [4:0]    rd_i,
    input  logic          wb_en_i,
    mem_access_if.master  mem,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [63:0]   wb_data_o,
    output logic [4:0]    rd_o,
    output logic          wb_en_o,
    output logic          exc_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_r, state_s;
    mem_op_t     op_s;
    mem_size_t   size_in_s, size_r;
    logic        accept_s, is_mem_s, is_store_s, trap_s;
    logic [63:0] addr_s, wdata_s, load_data_s;
    logic [7:0]  strb_s;
    logic [63:0] addr_r, wdata_r, wb_data_r;
    logic [7:0]  wstrb_r;
    logic        we_r, uns_r, wb_en_r, exc_r;
    logic [4:0]  rd_r;

    // Decode the incoming request: trap decision, effective address and store lanes.
    always_comb begin
        op_s       = mem_op_t'(mem_op_i);
        size_in_s  = mem_size_t'(mem_size_i);
        is_mem_s   = (op_s == MEM_LOAD) || (op_s == MEM_STORE);
`ifdef MISALIGN_TRAP_EN
        trap_s     = is_mem_s && is_misaligned(alu_res_i[2:0], size_in_s);
        addr_s     = alu_res_i;
`else
        trap_s     = 1'b0;
        addr_s     = {alu_res_i[63:3], alu_res_i[2:0] & align_bits(size_in_s)};
`endif
        is_store_s = (op_s == MEM_STORE) && !trap_s;
        strb_s     = size_mask(size_in_s) << addr_s[2:0];
        wdata_s    = store_data_i << {addr_s[2:0], 3'b000};
    end

    // Handshake: accept in IDLE, or in DONE when the current result is being consumed.
    always_comb begin
        ready_o  = (state_r == IDLE) || ((state_r == DONE) && ready_i);
        accept_s = valid_i && ready_o;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (accept_s) begin
                    state_s = (is_mem_s && !trap_s) ? REQ : DONE;
                end else if ((state_r == DONE) && ready_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            REQ: begin
                if (mem.req_ready_i) begin
                    state_s = we_r ? DONE : WAIT;
                end else begin
                    state_s = REQ;
                end
            end
            WAIT: begin
                if (mem.resp_valid_i) begin
                    state_s = DONE;
                end else begin
                    state_s = WAIT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    load_align u_load_align (
        .rdata       (mem.resp_rdata_i),
        .offset      (addr_r[2:0]),
        .size        (size_r),
        .is_unsigned (uns_r),
        .data        (load_data_s)
    );

    // State and transaction registers; request fields only change on accept, so they hold during REQ.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            addr_r    <= 64'd0;
            wdata_r   <= 64'd0;
            wstrb_r   <= 8'd0;
            we_r      <= 1'b0;
            size_r    <= SIZE_B;
            uns_r     <= 1'b0;
            rd_r      <= 5'd0;
            wb_en_r   <= 1'b0;
            wb_data_r <= 64'd0;
            exc_r     <= 1'b0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                addr_r    <= addr_s;
                wdata_r   <= is_store_s ? wdata_s : 64'd0;
                wstrb_r   <= is_store_s ? strb_s : 8'd0;
                we_r      <= is_store_s;
                size_r    <= size_in_s;
                uns_r     <= mem_unsigned_i;
                rd_r      <= rd_i;
                wb_en_r   <= wb_en_i && (op_s != MEM_STORE) && !trap_s;
                wb_data_r <= alu_res_i;
                exc_r     <= trap_s;
            end else if ((state_r == WAIT) && mem.resp_valid_i) begin
                wb_data_r <= load_data_s;
            end
        end
    end

    assign mem.req_valid_o = (state_r == REQ);
    assign mem.req_addr_o  = addr_r;
    assign mem.req_we_o    = we_r;
    assign mem.req_wdata_o = wdata_r;
    assign mem.req_wstrb_o = wstrb_r;

    assign valid_o   = (state_r == DONE);
    assign wb_data_o = wb_data_r;
    assign rd_o      = rd_r;
    assign wb_en_o   = wb_en_r;
    assign exc_o     = exc_r;

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access (expectations follow MISALIGN_TRAP_EN if defined).
`timescale 1ns/1ps
module tb_mem_access;
    import cpu_consts::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i, ready_o, mem_unsigned_i, wb_en_i;
    logic [63:0] alu_res_i, store_data_i;
    logic [1:0]  mem_op_i, mem_size_i;
    logic [4:0]  rd_i;
    logic        valid_o, ready_i, wb_en_o, exc_o;
    logic [63:0] wb_data_o;
    logic [4:0]  rd_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_if mem_if ();

    mem_access dut (
        .clk            (clk),
        .reset          (reset),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .alu_res_i      (alu_res_i),
        .store_data_i   (store_data_i),
        .mem_op_i       (mem_op_i),
        .mem_size_i     (mem_size_i),
        .mem_unsigned_i (mem_unsigned_i),
        .rd_i           (rd_i),
        .wb_en_i        (wb_en_i),
        .mem            (mem_if),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .wb_data_o      (wb_data_o),
        .rd_o           (rd_o),
        .wb_en_o        (wb_en_o),
        .exc_o          (exc_o)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [1:0] op, input logic [1:0] size, input logic uns,
                           input logic [63:0] addr, input logic [63:0] sdata, input logic [4:0] rd);
        mem_op_i       = op;
        mem_size_i     = size;
        mem_unsigned_i = uns;
        alu_res_i      = addr;
        store_data_i   = sdata;
        rd_i           = rd;
        wb_en_i        = 1'b1;
        valid_i        = 1'b1;
    endtask

    task automatic accept(input logic [1:0] op, input logic [1:0] size, input logic uns,
                          input logic [63:0] addr, input logic [63:0] sdata, input logic [4:0] rd);
        set_req(op, size, uns, addr, sdata, rd);
        tick();
        valid_i = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        valid_i = 1'b0; ready_i = 1'b0; wb_en_i = 1'b0; mem_unsigned_i = 1'b0;
        alu_res_i = 64'd0; store_data_i = 64'd0; mem_op_i = 2'd0; mem_size_i = 2'd0; rd_i = 5'd0;
        mem_if.req_ready_i = 1'b0; mem_if.resp_valid_i = 1'b0; mem_if.resp_rdata_i = 64'd0;
        tick(); tick();
        reset = 1'b0;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        n_checks++; if (mem_if.req_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", mem_if.req_valid_o); end
        n_checks++; if ({exc_o, wb_en_o, mem_if.req_we_o} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {exc_o, wb_en_o, mem_if.req_we_o}); end
        n_checks++; if ({wb_data_o, rd_o} !== 69'd0) begin n_fail++; $display("FAIL reset_wb: got %h/%h expected 0/0", wb_data_o, rd_o); end
        n_checks++; if ({mem_if.req_addr_o, mem_if.req_wdata_o, mem_if.req_wstrb_o} !== 136'd0) begin n_fail++; $display("FAIL reset_req_fields: got %h %h %h expected 0", mem_if.req_addr_o, mem_if.req_wdata_o, mem_if.req_wstrb_o); end
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
    endtask

    task automatic test_none;
        ready_i = 1'b0;
        accept(MEM_NONE, SIZE_D, 1'b0, 64'h1234, 64'd0, 5'd5);
        n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL none_valid: got %b expected 1", valid_o); end
        n_checks++; if (wb_data_o !== 64'h1234) begin n_fail++; $display("FAIL none_data: got %h expected 1234", wb_data_o); end
        n_checks++; if ({rd_o, wb_en_o} !== {5'd5, 1'b1}) begin n_fail++; $display("FAIL none_rd_en: got %0d/%b expected 5/1", rd_o, wb_en_o); end
        n_checks++; if (mem_if.req_valid_o !== 1'b0) begin n_fail++; $display("FAIL none_no_req: got %b expected 0", mem_if.req_valid_o); end
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL none_retire: got %b expected 0", valid_o); end
    endtask

    task automatic run_load(input string name, input logic [1:0] size, input logic uns,
                            input logic [63:0] addr, input logic [63:0] exp_addr,
                            input logic [63:0] rdata, input logic [63:0] exp_data);
        accept(MEM_LOAD, size, uns, addr, 64'd0, 5'd7);
        n_checks++; if ({mem_if.req_valid_o, mem_if.req_we_o} !== 2'b10) begin n_fail++; $display("FAIL %s_req: got valid/we %b expected 10", name, {mem_if.req_valid_o, mem_if.req_we_o}); end
        n_checks++; if (mem_if.req_addr_o !== exp_addr) begin n_fail++; $display("FAIL %s_addr: got %h expected %h", name, mem_if.req_addr_o, exp_addr); end
        mem_if.req_ready_i = 1'b1;
        tick();
        mem_if.req_ready_i = 1'b0;
        n_checks++; if ({mem_if.req_valid_o, valid_o} !== 2'b00) begin n_fail++; $display("FAIL %s_wait: got req/valid %b expected 00", name, {mem_if.req_valid_o, valid_o}); end
        mem_if.resp_valid_i = 1'b1;
        mem_if.resp_rdata_i = rdata;
        tick();
        mem_if.resp_valid_i = 1'b0;
        mem_if.resp_rdata_i = 64'd0;
        n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL %s_valid: got %b expected 1", name, valid_o); end
        n_checks++; if (wb_data_o !== exp_data) begin n_fail++; $display("FAIL %s_data: got %h expected %h", name, wb_data_o, exp_data); end
        n_checks++; if ({rd_o, wb_en_o, exc_o} !== {5'd7, 1'b1, 1'b0}) begin n_fail++; $display("FAIL %s_wb: got rd %0d en %b exc %b expected 7 1 0", name, rd_o, wb_en_o, exc_o); end
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
    endtask

    task automatic test_load;
        run_load("ld_b_s", SIZE_B, 1'b0, 64'h1003, 64'h1003, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
        run_load("ld_b_u", SIZE_B, 1'b1, 64'h1003, 64'h1003, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080);
        run_load("ld_w_s", SIZE_W, 1'b0, 64'h1004, 64'h1004, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
        run_load("ld_h_s", SIZE_H, 1'b0, 64'h100E, 64'h100E, 64'h7FFF_0000_0000_0000, 64'h0000_0000_0000_7FFF);
        run_load("ld_d_u", SIZE_D, 1'b1, 64'h1008, 64'h1008, 64'hF000_0000_0000_0001, 64'hF000_0000_0000_0001);
    endtask

    task automatic test_store;
        accept(MEM_STORE, SIZE_H, 1'b0, 64'h1006, 64'hABCD, 5'd3);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) mem_if.req_ready_i = 1'b1;
            n_checks++; if ({mem_if.req_valid_o, mem_if.req_we_o} !== 2'b11) begin n_fail++; $display("FAIL st_req%0d: got valid/we %b expected 11", i, {mem_if.req_valid_o, mem_if.req_we_o}); end
            n_checks++; if ({mem_if.req_wstrb_o, mem_if.req_addr_o} !== {8'hC0, 64'h1006}) begin n_fail++; $display("FAIL st_strb_addr%0d: got %h %h expected c0 1006", i, mem_if.req_wstrb_o, mem_if.req_addr_o); end
            n_checks++; if (mem_if.req_wdata_o !== 64'hABCD_0000_0000_0000) begin n_fail++; $display("FAIL st_wdata%0d: got %h expected abcd000000000000", i, mem_if.req_wdata_o); end
            mem_if.resp_valid_i = (i == 0);
            tick();
            mem_if.resp_valid_i = 1'b0;
        end
        mem_if.req_ready_i = 1'b0;
        n_checks++; if ({valid_o, wb_en_o, exc_o, mem_if.req_valid_o} !== 4'b1000) begin n_fail++; $display("FAIL st_done: got valid/en/exc/req %b expected 1000", {valid_o, wb_en_o, exc_o, mem_if.req_valid_o}); end
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
    endtask

    task automatic test_misaligned;
`ifdef MISALIGN_TRAP_EN
        accept(MEM_LOAD, SIZE_W, 1'b0, 64'h1002, 64'd0, 5'd4);
        n_checks++; if ({valid_o, exc_o, wb_en_o, mem_if.req_valid_o} !== 4'b1100) begin n_fail++; $display("FAIL mis_trap: got valid/exc/en/req %b expected 1100", {valid_o, exc_o, wb_en_o, mem_if.req_valid_o}); end
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        n_checks++; if ({valid_o, mem_if.req_valid_o} !== 2'b00) begin n_fail++; $display("FAIL mis_retire: got %b expected 00", {valid_o, mem_if.req_valid_o}); end
`else
        run_load("mis_w", SIZE_W, 1'b0, 64'h1002, 64'h1000, 64'h1122_3344_5566_7788, 64'h0000_0000_5566_7788);
`endif
    endtask

    task automatic test_done_stall;
        ready_i = 1'b0;
        accept(MEM_NONE, SIZE_D, 1'b0, 64'hDEAD, 64'd0, 5'd9);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if ({valid_o, ready_o} !== 2'b10) begin n_fail++; $display("FAIL stall_hs%0d: got valid/ready %b expected 10", i, {valid_o, ready_o}); end
            n_checks++; if ({wb_data_o, rd_o} !== {64'hDEAD, 5'd9}) begin n_fail++; $display("FAIL stall_data%0d: got %h/%0d expected dead/9", i, wb_data_o, rd_o); end
            tick();
        end
        ready_i = 1'b1;
        #1;
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL stall_release: got %b expected 1", ready_o); end
        tick();
        ready_i = 1'b0;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL stall_idle: got %b expected 0", valid_o); end
    endtask

    task automatic test_back_to_back;
        accept(MEM_NONE, SIZE_D, 1'b0, 64'h11, 64'd0, 5'd1);
        ready_i = 1'b1;
        set_req(MEM_NONE, SIZE_D, 1'b0, 64'h22, 64'd0, 5'd2);
        tick();
        n_checks++; if ({valid_o, wb_data_o, rd_o} !== {1'b1, 64'h22, 5'd2}) begin n_fail++; $display("FAIL b2b_none: got %b %h %0d expected 1 22 2", valid_o, wb_data_o, rd_o); end
        set_req(MEM_STORE, SIZE_B, 1'b0, 64'h3001, 64'h5A, 5'd0);
        tick();
        valid_i = 1'b0;
        ready_i = 1'b0;
        n_checks++; if ({valid_o, mem_if.req_valid_o, mem_if.req_wstrb_o} !== {1'b0, 1'b1, 8'h02}) begin n_fail++; $display("FAIL b2b_store: got valid %b req %b strb %h expected 0 1 02", valid_o, mem_if.req_valid_o, mem_if.req_wstrb_o); end
        n_checks++; if (mem_if.req_wdata_o !== 64'h5A00) begin n_fail++; $display("FAIL b2b_wdata: got %h expected 5a00", mem_if.req_wdata_o); end
        mem_if.req_ready_i = 1'b1;
        tick();
        mem_if.req_ready_i = 1'b0;
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
    endtask

    task automatic test_reset_in_wait;
        accept(MEM_LOAD, SIZE_D, 1'b0, 64'h2000, 64'd0, 5'd6);
        mem_if.req_ready_i = 1'b1;
        tick();
        mem_if.req_ready_i = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if ({mem_if.req_valid_o, valid_o} !== 2'b00) begin n_fail++; $display("FAIL rst_wait: got req/valid %b expected 00", {mem_if.req_valid_o, valid_o}); end
        mem_if.resp_valid_i = 1'b1;
        mem_if.resp_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        mem_if.resp_valid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++; if ({valid_o, mem_if.req_valid_o, ready_o} !== 3'b001) begin n_fail++; $display("FAIL rst_late_resp%0d: got valid/req/ready %b expected 001", i, {valid_o, mem_if.req_valid_o, ready_o}); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_none();
        test_load();
        test_store();
        test_misaligned();
        test_done_stall();
        test_back_to_back();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
